// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, stage-count helper and op-mode codes
// for the segmented adder pipeline.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int num_stages(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg: one SEG-bit slice of the adder pipeline, registered
// sum and carry with advance enable and synchronous reset.
module adder_seg
    import adder_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= total[SEG-1:0];
            cout <= total[SEG];
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/sub, SEG bits per stage, valid/ready stream.
// Define ADDER_PIPE_OVF_EN to add the signed-overflow output ovf.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef ADDER_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             cy
);

    localparam int STAGES = num_stages(WIDTH, SEG);

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("adder_pipe: WIDTH must be a multiple of SEG");
    end

    logic              adv;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  res  [STAGES];
    logic [STAGES-1:0] carry;
    logic [STAGES-1:0] vld;
    logic              unused_ops;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign a_in[0] = in_data1;
    assign b_in[0] = (in_sub == OP_SUB) ? ~in_data2 : in_data2;

    // Last stage only consumes the low slice of its operand words.
    assign unused_ops = ^{a_in[STAGES-1], b_in[STAGES-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic           c_in;
        logic [SEG-1:0] sum;
        logic           v_q;

        adder_seg #(.SEG(SEG)) u_seg (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .a    (a_in[k][SEG-1:0]),
            .b    (b_in[k][SEG-1:0]),
            .cin  (c_in),
            .sum  (sum),
            .cout (carry[k])
        );

        if (k == 0) begin : g_head
            assign c_in   = (in_sub == OP_SUB) ? 1'b1 : in_cin;
            assign res[k] = WIDTH'(sum);

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= in_valid;
                end
            end
        end else begin : g_body
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] lo_q;

            assign c_in    = carry[k-1];
            assign a_in[k] = a_q;
            assign b_in[k] = b_q;
            assign res[k]  = lo_q | (WIDTH'(sum) << (k * SEG));

            // Operands shift down so slice k sits at the low end.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    lo_q <= '0;
                    v_q  <= 1'b0;
                end else if (adv) begin
                    a_q  <= a_in[k-1] >> SEG;
                    b_q  <= b_in[k-1] >> SEG;
                    lo_q <= res[k-1];
                    v_q  <= vld[k-1];
                end
            end
        end

        assign vld[k] = v_q;
    end

    assign out_valid = vld[STAGES-1];
    assign out_data  = res[STAGES-1];
    assign cy        = carry[STAGES-1];

`ifdef ADDER_PIPE_OVF_EN
    logic msb_x_q;

    // Carry into MSB recovered as a_msb ^ b_msb ^ sum_msb.
    always_ff @(posedge clk) begin
        if (rst) begin
            msb_x_q <= 1'b0;
        end else if (adv) begin
            msb_x_q <= a_in[STAGES-1][SEG-1] ^ b_in[STAGES-1][SEG-1];
        end
    end

    assign ovf = msb_x_q ^ out_data[WIDTH-1] ^ cy;
`endif

endmodule
